// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : reorder_buffer
//  Description : Circular in-order reorder buffer. Rename/dispatch writes one
//                entry per cycle, execute marks entries done by index, and the
//                oldest done entry retires each cycle, handing its displaced
//                physical register back to the free list.
//  Revision    : 1.0  initial release
// ============================================================================
module reorder_buffer #(
    parameter int ROB_DEPTH = 8,
    parameter int PREG_W    = 5,
    parameter int AREG_W    = 5,
    localparam int IDX_W    = $clog2(ROB_DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,

    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic              dispatch_has_dest,
    input  logic [AREG_W-1:0] dispatch_arch_dest,
    input  logic [PREG_W-1:0] dispatch_phys_dest,
    input  logic [PREG_W-1:0] dispatch_old_phys,
    output logic [IDX_W-1:0]  dispatch_rob_idx,

    input  logic              complete_valid,
    input  logic [IDX_W-1:0]  complete_rob_idx,

    output logic              commit_valid,
    output logic              commit_has_dest,
    output logic [AREG_W-1:0] commit_arch_dest,
    output logic [PREG_W-1:0] commit_phys_dest,
    output logic [PREG_W-1:0] commit_old_phys,

    output logic [IDX_W:0]    count,
    output logic              empty,
    output logic              full
);

    // Per-entry state
    logic [ROB_DEPTH-1:0] valid_q,    valid_d;
    logic [ROB_DEPTH-1:0] done_q,     done_d;
    logic [ROB_DEPTH-1:0] has_dest_q, has_dest_d;
    logic [AREG_W-1:0]    arch_q     [ROB_DEPTH];
    logic [AREG_W-1:0]    arch_d     [ROB_DEPTH];
    logic [PREG_W-1:0]    phys_q     [ROB_DEPTH];
    logic [PREG_W-1:0]    phys_d     [ROB_DEPTH];
    logic [PREG_W-1:0]    old_phys_q [ROB_DEPTH];
    logic [PREG_W-1:0]    old_phys_d [ROB_DEPTH];

    // Pointers and occupancy
    logic [IDX_W-1:0]     head_q,  head_d;
    logic [IDX_W-1:0]     tail_q,  tail_d;
    logic [IDX_W:0]       count_q, count_d;

    logic                 dispatch_fire;
    logic                 commit_fire;
    logic                 complete_hit;

    // Status, handshake and commit payload straight from the head entry
    always_comb begin
        full             = (count_q == (IDX_W+1)'(ROB_DEPTH));
        empty            = (count_q == '0);
        count            = count_q;
        dispatch_ready   = !full;
        dispatch_rob_idx = tail_q;
        dispatch_fire    = dispatch_valid && !full;
        commit_fire      = valid_q[head_q] && done_q[head_q] && !flush;
        commit_valid     = commit_fire;
        commit_has_dest  = has_dest_q[head_q];
        commit_arch_dest = arch_q[head_q];
        commit_phys_dest = phys_q[head_q];
        commit_old_phys  = old_phys_q[head_q];
        // A completion that lands on the slot being written this cycle is
        // dropped so the fresh entry always starts not-done.
        complete_hit     = complete_valid && valid_q[complete_rob_idx]
                           && !(dispatch_fire && (complete_rob_idx == tail_q));
    end

    // Next-state: flush wipes everything, otherwise complete, retire, allocate
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        has_dest_d = has_dest_q;
        arch_d     = arch_q;
        phys_d     = phys_q;
        old_phys_d = old_phys_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (complete_hit) begin
                done_d[complete_rob_idx] = 1'b1;
            end
            if (commit_fire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + IDX_W'(1);
            end
            // Dispatch never targets the head while it retires: a firing
            // dispatch implies not full, so the tail slot is free.
            if (dispatch_fire) begin
                valid_d[tail_q]    = 1'b1;
                done_d[tail_q]     = 1'b0;
                has_dest_d[tail_q] = dispatch_has_dest;
                arch_d[tail_q]     = dispatch_arch_dest;
                phys_d[tail_q]     = dispatch_phys_dest;
                old_phys_d[tail_q] = dispatch_old_phys;
                tail_d             = tail_q + IDX_W'(1);
            end
            count_d = count_q + (IDX_W+1)'(dispatch_fire)
                              - (IDX_W+1)'(commit_fire);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= '0;
            done_q     <= '0;
            has_dest_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                arch_q[i]     <= '0;
                phys_q[i]     <= '0;
                old_phys_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            has_dest_q <= has_dest_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                arch_q[i]     <= arch_d[i];
                phys_q[i]     <= phys_d[i];
                old_phys_q[i] <= old_phys_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reorder_buffer
//  Description : Self-checking bench for reorder_buffer. A program-order queue
//                of in-flight instructions serves as the reference; directed
//                scenarios are followed by a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reorder_buffer;

    localparam int ROB_DEPTH = 8;
    localparam int PREG_W    = 5;
    localparam int AREG_W    = 5;
    localparam int IDX_W     = $clog2(ROB_DEPTH);

    logic              clock;
    logic              reset;
    logic              flush;
    logic              dispatch_valid;
    logic              dispatch_ready;
    logic              dispatch_has_dest;
    logic [AREG_W-1:0] dispatch_arch_dest;
    logic [PREG_W-1:0] dispatch_phys_dest;
    logic [PREG_W-1:0] dispatch_old_phys;
    logic [IDX_W-1:0]  dispatch_rob_idx;
    logic              complete_valid;
    logic [IDX_W-1:0]  complete_rob_idx;
    logic              commit_valid;
    logic              commit_has_dest;
    logic [AREG_W-1:0] commit_arch_dest;
    logic [PREG_W-1:0] commit_phys_dest;
    logic [PREG_W-1:0] commit_old_phys;
    logic [IDX_W:0]    count;
    logic              empty;
    logic              full;

    reorder_buffer #(
        .ROB_DEPTH (ROB_DEPTH),
        .PREG_W    (PREG_W),
        .AREG_W    (AREG_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_has_dest  (dispatch_has_dest),
        .dispatch_arch_dest (dispatch_arch_dest),
        .dispatch_phys_dest (dispatch_phys_dest),
        .dispatch_old_phys  (dispatch_old_phys),
        .dispatch_rob_idx   (dispatch_rob_idx),
        .complete_valid     (complete_valid),
        .complete_rob_idx   (complete_rob_idx),
        .commit_valid       (commit_valid),
        .commit_has_dest    (commit_has_dest),
        .commit_arch_dest   (commit_arch_dest),
        .commit_phys_dest   (commit_phys_dest),
        .commit_old_phys    (commit_old_phys),
        .count              (count),
        .empty              (empty),
        .full               (full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: in-flight instructions oldest-first
    typedef struct {
        int idx;
        bit hd;
        int arch;
        int phys;
        int old;
        bit done;
    } ent_t;

    ent_t q[$];
    int   m_tail   = 0;
    bit   model_ok = 1'b0;
    int   vectors  = 0;
    int   miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare outputs against the model, clock, update model
    task automatic cyc(input bit r, input bit f, input bit dv, input bit hd,
                       input int ar, input int ph, input int ol,
                       input bit cv, input int ci);
        bit   exp_cv;
        bit   commit;
        bit   fire;
        ent_t tmp;
        reset              = r;
        flush              = f;
        dispatch_valid     = dv;
        dispatch_has_dest  = hd;
        dispatch_arch_dest = AREG_W'(ar);
        dispatch_phys_dest = PREG_W'(ph);
        dispatch_old_phys  = PREG_W'(ol);
        complete_valid     = cv;
        complete_rob_idx   = IDX_W'(ci);
        #1;
        if (model_ok) begin
            exp_cv = !f && (q.size() > 0) && q[0].done;
            check_val("ready",   32'(dispatch_ready),   32'(q.size() < ROB_DEPTH));
            check_val("rob_idx", 32'(dispatch_rob_idx), 32'(m_tail));
            check_val("count",   32'(count),            32'(q.size()));
            check_val("empty",   32'(empty),            32'(q.size() == 0));
            check_val("full",    32'(full),             32'(q.size() == ROB_DEPTH));
            check_val("commit_valid", 32'(commit_valid), 32'(exp_cv));
            if (exp_cv) begin
                check_val("commit_has_dest", 32'(commit_has_dest),  32'(q[0].hd));
                check_val("commit_arch",     32'(commit_arch_dest), 32'(q[0].arch));
                check_val("commit_phys",     32'(commit_phys_dest), 32'(q[0].phys));
                check_val("commit_old",      32'(commit_old_phys),  32'(q[0].old));
            end
        end
        @(posedge clock);
        if (r || f) begin
            q.delete();
            m_tail = 0;
            if (r) model_ok = 1'b1;
        end else if (model_ok) begin
            commit = (q.size() > 0) && q[0].done;
            fire   = dv && (q.size() < ROB_DEPTH);
            if (cv) begin
                foreach (q[i]) begin
                    if (q[i].idx == ci && !(fire && ci == m_tail)) q[i].done = 1'b1;
                end
            end
            if (commit) tmp = q.pop_front();
            if (fire) begin
                q.push_back('{m_tail, hd, ar, ph, ol, 1'b0});
                m_tail = (m_tail + 1) % ROB_DEPTH;
            end
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic complete(input int ci);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, ci);
    endtask

    task automatic disp(input int ph, input int ol);
        cyc(0, 0, 1, 1, int'($urandom_range(0, 31)), ph, ol, 0, 0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_has_dest = 1'b0;
        dispatch_arch_dest = '0; dispatch_phys_dest = '0; dispatch_old_phys = '0;
        complete_valid = 1'b0; complete_rob_idx = '0;
        @(negedge clock);

        // Fill from reset: phys 8..15 land at indices 0..7
        do_reset();
        for (int i = 0; i < 8; i++) disp(8 + i, 16 + i);
        check_val("fill_full",  32'(full),  32'd1);
        check_val("fill_count", 32'(count), 32'd8);
        idle();

        // Out-of-order completion, in-order retirement
        complete(2);
        complete(0);
        check_val("ooo_commit0",  32'(commit_valid),    32'd1);
        check_val("ooo_old0",     32'(commit_old_phys), 32'd16);
        idle();
        check_val("ooo_idx2_waits", 32'(commit_valid), 32'd0);
        complete(1);
        idle();
        idle();

        // Full ROB: commit frees a slot but dispatch stalls the same cycle
        for (int i = 0; i < 3; i++) disp(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        check_val("refill_full", 32'(full), 32'd1);
        cyc(0, 0, 1, 1, 3, 4, 5, 1, q[0].idx);
        cyc(0, 0, 1, 1, 3, 4, 5, 0, 0);
        check_val("stall_count", 32'(count), 32'd7);

        // Steady dispatch+commit with wrap-around
        do_reset();
        for (int i = 0; i < 4; i++) disp(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        complete(0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 1, 1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                int'($urandom_range(0, 31)), 1, q[1].idx);
        check_val("steady_count", 32'(count), 32'd4);

        // Flush squashes a done head
        do_reset();
        for (int i = 0; i < 3; i++) disp(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        complete(2);
        complete(1);
        complete(0);
        cyc(0, 1, 1, 1, 1, 2, 3, 1, 0);
        check_val("flush_empty",   32'(empty),            32'd1);
        check_val("flush_rob_idx", 32'(dispatch_rob_idx), 32'd0);
        idle();

        // Completion to an empty slot leaves no trace
        do_reset();
        complete(5);
        for (int i = 0; i < 6; i++) disp(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        for (int i = 0; i < 5; i++) complete(i);
        idle();
        idle();
        check_val("stale_idx5_notdone", 32'(commit_valid), 32'd0);
        check_val("stale_count",        32'(count),        32'd1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 3) != 0), 1'($urandom),
                int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                ($urandom_range(0, 2) != 0), int'($urandom_range(0, ROB_DEPTH - 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
